multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Sequential successor to the single-cycle MIPS control decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states with a memory-ready handshake and drives the shared multicycle datapath (PC, IR, register bank, ALU, data memory). It adds the previously missing iterative DIV/MFHI/MFLO support through a HI/LO wait counter. Decode tables are parametrised in width so the datapath can grow without re-editing the FSM.

Parameters:
- OPALU_W, 3: width of the opALU code sent to alu_control.
- DIV_CYCLES, 32: fixed divider latency in cycles, minimum 2.
- RESET_PC_SRC, 2'b11: pc_src value during reset and idle (PC+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- rt  in  5  IR[20:16]; selects between BGEZ and BGEZAL.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_src  out  2  00 branch, 01 jump, 10 rs, 11 PC+1.
- reg_dst  out  2  0 rt, 1 rd, 2 $ra.
- mem_to_reg  out  1  write-back from data memory.
- hilo_rd  out  2  00 none, 01 HI, 10 LO (write-back source override).
- opALU  out  OPALU_W  ALU operation class.
- origALU  out  1  second ALU operand is the immediate.
- equal  out  1  branch condition sense.
- mem_read  out  1  memory read request.
- write_enable_mem  out  1  data memory write.
- write_enable_reg  out  1  register bank write; one-cycle pulse.
- ir_write  out  1  latch IR.
- pc_write  out  1  PC update; datapath qualifies branch updates with the ALU result and equal.
- div_start  out  1  one-cycle divider start pulse.
- hilo_write  out  1  one-cycle pulse that latches HI/LO.
- busy  out  1  high in every state except FETCH.

Behaviour:
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, DIV_WAIT, plus TRAP when the optional feature is built in.
- Asynchronous reset:
  - state goes to RESET and the divider counter clears to 0.
  - All enables and pulses are 0; pc_src=RESET_PC_SRC; equal=1; reg_dst=0; opALU=0.
  - RESET always moves to FETCH on the next edge.
- FETCH:
  - mem_read=1; the FSM holds while mem_ready=0.
  - When mem_ready=1, ir_write=1 and pc_write=1 with pc_src=11 in the same cycle, then go to DECODE.
- DECODE:
  - One cycle; the instruction class is registered from opcode/funct/rt.
  - Field encodings are identical to the single-cycle decoder: ADDI/LW/SW add, ANDI and, ORI or, XORI xor, BEQ/BNE subtract, REGIMM special 3'b111, R-type 3'b110.
- EXEC (one cycle), by instruction class:
  - R-type, I-type ALU, MUL: go to WB.
  - LW, SW: go to MEM.
  - BEQ, BNE, BGEZ: pc_write=1, pc_src=00, equal=1 for BEQ and 0 for BNE; go to FETCH.
  - BGEZAL: same as BGEZ, plus write_enable_reg=1 and reg_dst=2.
  - J: pc_write=1, pc_src=01.
  - JAL: as J, plus write_enable_reg=1 and reg_dst=2.
  - JR: pc_write=1, pc_src=10.
  - JALR: as JR, plus write_enable_reg=1 and reg_dst=2.
  - All jump classes go to FETCH.
  - DIV: div_start=1; go to DIV_WAIT with the counter loaded to DIV_CYCLES-1.
- MEM:
  - LW: mem_read=1; wait on mem_ready, then go to WB.
  - SW: write_enable_mem=1 is held until mem_ready, then go to FETCH.
  - write_enable_mem must never be high in any other state.
- WB:
  - write_enable_reg=1 for one cycle, then go to FETCH.
  - LW sets mem_to_reg=1.
  - MFHI sets hilo_rd=01; MFLO sets hilo_rd=10.
- DIV_WAIT:
  - The counter decrements each cycle.
  - At 0: hilo_write=1 for one cycle, then go to FETCH.
- Simultaneous events: reset overrides everything. A reset during DIV_WAIT or MEM aborts with no hilo_write and no write_enable_reg pulse.
- Unknown opcode, or unknown funct under opcode 0: treated as NOP (EXEC goes straight to FETCH with no writes).
- Outputs are a Moore decode of the registered state and the registered class; they are glitch-free with respect to opcode changes mid-state.
- Cycle counts with zero-wait memory:
  - ALU ops: 4 cycles.
  - LW: 5 cycles.
  - SW, branch, jump: 3 or 4 cycles.
  - DIV: 3+DIV_CYCLES cycles.

Optional Feature:
Macro MCU_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode or funct goes from EXEC to TRAP. TRAP asserts pc_write=1 with pc_src=01 for one cycle (the datapath supplies the exception vector), with no register or memory writes, then goes to FETCH.
- Undefined: NOP behaviour as above, and no TRAP state exists.

Decomposition:
- Package mcu_pkg holds:
  - the state enum;
  - instruction-class enum (ALU_R, ALU_I, LOAD, STORE, BRANCH, REGIMM, JUMP, JUMP_LINK, JREG, JREG_LINK, DIV, MFHILO, NOP);
  - opcode/funct localparams;
  - pc_src and reg_dst encodings.
- Sub-module mcu_decode: combinational opcode/funct/rt to class plus opALU/origALU; its output is registered in DECODE.

Test Plan:
- ADDI after reset, mem_ready always 1 -> ir_write in cycle 2, write_enable_reg pulses exactly once in cycle 5 with reg_dst=0, opALU=000, origALU=1.
- LW with mem_ready low for 2 cycles in both FETCH and MEM -> mem_read held through each stall; WB has mem_to_reg=1; total 9 cycles.
- DIV with DIV_CYCLES=4 -> single div_start pulse, hilo_write exactly 4 cycles later, busy=1 throughout; MFLO next -> hilo_rd=10 in WB.
- BNE -> in EXEC pc_write=1, pc_src=00, equal=0; BGEZAL (rt=10001) -> reg_dst=2 and write_enable_reg=1 in the same cycle.
- rst_n low in the 2nd DIV_WAIT cycle -> all outputs at reset values asynchronously, no hilo_write, restart in FETCH.
- Opcode 6'b111111 -> without the macro, FETCH after EXEC with no writes; with MCU_ILLEGAL_TRAP_EN, one TRAP cycle with pc_src=01 and pc_write=1.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// MCU_ILLEGAL_TRAP_EN adds the TRAP state for unknown opcodes/functs.
package mcu_pkg;

  typedef enum logic [2:0] {
    RESET,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    DIV_WAIT
`ifdef MCU_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_e;

  typedef enum logic [3:0] {
    ALU_R,
    ALU_I,
    LOAD,
    STORE,
    BRANCH,
    REGIMM,
    JUMP,
    JUMP_LINK,
    JREG,
    JREG_LINK,
    DIV,
    MFHILO,
    NOP
  } iclass_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_JALR  = 6'b001001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_XOR    = 3'b100;
  localparam logic [2:0] ALU_RTYPE  = 3'b110;
  localparam logic [2:0] ALU_REGIMM = 3'b111;

  localparam logic [1:0] PC_SRC_BRANCH = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_RS     = 2'b10;
  localparam logic [1:0] PC_SRC_INC    = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;

  typedef struct packed {
    iclass_e    cls;
    logic [2:0] op_alu;
    logic       orig_alu;
    logic       equal;
    logic       link;
    logic [1:0] hilo_sel;
  } dec_t;

  localparam dec_t DEC_NOP = '{cls: NOP, op_alu: ALU_ADD, orig_alu: 1'b0,
                               equal: 1'b1, link: 1'b0, hilo_sel: HILO_NONE};

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction-class decode; the control FSM registers
// its output during DECODE.
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] rt_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = DEC_NOP;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          F_SLL, F_SRL, F_SRA, F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
          F_XOR, F_NOR, F_SLT, F_SLTU, F_MULT, F_MULTU: begin
            dec_o.cls    = ALU_R;
            dec_o.op_alu = ALU_RTYPE;
          end
          F_DIV, F_DIVU: begin
            dec_o.cls    = DIV;
            dec_o.op_alu = ALU_RTYPE;
          end
          F_MFHI: begin
            dec_o.cls      = MFHILO;
            dec_o.op_alu   = ALU_RTYPE;
            dec_o.hilo_sel = HILO_HI;
          end
          F_MFLO: begin
            dec_o.cls      = MFHILO;
            dec_o.op_alu   = ALU_RTYPE;
            dec_o.hilo_sel = HILO_LO;
          end
          F_JR: begin
            dec_o.cls    = JREG;
            dec_o.op_alu = ALU_RTYPE;
          end
          F_JALR: begin
            dec_o.cls    = JREG_LINK;
            dec_o.op_alu = ALU_RTYPE;
            dec_o.link   = 1'b1;
          end
          default: dec_o = DEC_NOP;
        endcase
      end
      OP_REGIMM: begin
        if (rt_i == RT_BGEZ || rt_i == RT_BGEZAL) begin
          dec_o.cls    = REGIMM;
          dec_o.op_alu = ALU_REGIMM;
          dec_o.link   = (rt_i == RT_BGEZAL);
        end
      end
      OP_J: dec_o.cls = JUMP;
      OP_JAL: begin
        dec_o.cls  = JUMP_LINK;
        dec_o.link = 1'b1;
      end
      OP_BEQ: begin
        dec_o.cls    = BRANCH;
        dec_o.op_alu = ALU_SUB;
      end
      OP_BNE: begin
        dec_o.cls    = BRANCH;
        dec_o.op_alu = ALU_SUB;
        dec_o.equal  = 1'b0;
      end
      OP_ADDI: begin
        dec_o.cls      = ALU_I;
        dec_o.orig_alu = 1'b1;
      end
      OP_ANDI: begin
        dec_o.cls      = ALU_I;
        dec_o.op_alu   = ALU_AND;
        dec_o.orig_alu = 1'b1;
      end
      OP_ORI: begin
        dec_o.cls      = ALU_I;
        dec_o.op_alu   = ALU_OR;
        dec_o.orig_alu = 1'b1;
      end
      OP_XORI: begin
        dec_o.cls      = ALU_I;
        dec_o.op_alu   = ALU_XOR;
        dec_o.orig_alu = 1'b1;
      end
      OP_LW: begin
        dec_o.cls      = LOAD;
        dec_o.orig_alu = 1'b1;
      end
      OP_SW: begin
        dec_o.cls      = STORE;
        dec_o.orig_alu = 1'b1;
      end
      default: dec_o = DEC_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory handshake and iterative DIV wait.
// Define MCU_ILLEGAL_TRAP_EN to route unknown instructions through TRAP.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned OPALU_W      = 3,
  parameter int unsigned DIV_CYCLES   = 32,
  parameter logic [1:0]  RESET_PC_SRC = 2'b11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [4:0]         rt,
  input  logic               mem_ready,
  output logic [1:0]         pc_src,
  output logic [1:0]         reg_dst,
  output logic               mem_to_reg,
  output logic [1:0]         hilo_rd,
  output logic [OPALU_W-1:0] opALU,
  output logic               origALU,
  output logic               equal,
  output logic               mem_read,
  output logic               write_enable_mem,
  output logic               write_enable_reg,
  output logic               ir_write,
  output logic               pc_write,
  output logic               div_start,
  output logic               hilo_write,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  state_e           state_q, state_d;
  dec_t             dec_q, dec_d;
  dec_t             dec_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  mcu_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .rt_i     (rt),
    .dec_o    (dec_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET;
      dec_q   <= DEC_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    dec_d            = dec_q;
    cnt_d            = cnt_q;
    pc_src           = RESET_PC_SRC;
    reg_dst          = REG_DST_RT;
    mem_to_reg       = 1'b0;
    hilo_rd          = HILO_NONE;
    opALU            = '0;
    origALU          = 1'b0;
    equal            = 1'b1;
    mem_read         = 1'b0;
    write_enable_mem = 1'b0;
    write_enable_reg = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    div_start        = 1'b0;
    hilo_write       = 1'b0;
    busy             = (state_q != FETCH);

    // ALU controls come only from the registered class, never from live IR bits
    if (state_q == EXEC || state_q == MEM || state_q == WB || state_q == DIV_WAIT) begin
      opALU   = OPALU_W'(dec_q.op_alu);
      origALU = dec_q.orig_alu;
    end

    case (state_q)
      RESET: state_d = FETCH;

      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_INC;
          state_d  = DECODE;
        end
      end

      DECODE: begin
        dec_d   = dec_w;
        state_d = EXEC;
      end

      EXEC: begin
        case (dec_q.cls)
          ALU_R, ALU_I, MFHILO: state_d = WB;
          LOAD, STORE:          state_d = MEM;
          BRANCH, REGIMM: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_BRANCH;
            equal    = dec_q.equal;
            state_d  = FETCH;
          end
          JUMP, JUMP_LINK: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            state_d  = FETCH;
          end
          JREG, JREG_LINK: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_RS;
            state_d  = FETCH;
          end
          DIV: begin
            div_start = 1'b1;
            cnt_d     = CNT_W'(DIV_CYCLES - 1);
            state_d   = DIV_WAIT;
          end
          default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
            state_d = TRAP;
`else
            state_d = FETCH;
`endif
          end
        endcase
        if (dec_q.link) begin
          write_enable_reg = 1'b1;
          reg_dst          = REG_DST_RA;
        end
      end

      MEM: begin
        if (dec_q.cls == LOAD) mem_read = 1'b1;
        else                   write_enable_mem = 1'b1;
        if (mem_ready) state_d = (dec_q.cls == LOAD) ? WB : FETCH;
      end

      WB: begin
        write_enable_reg = 1'b1;
        reg_dst          = (dec_q.cls == ALU_I || dec_q.cls == LOAD) ? REG_DST_RT : REG_DST_RD;
        mem_to_reg       = (dec_q.cls == LOAD);
        hilo_rd          = dec_q.hilo_sel;
        state_d          = FETCH;
      end

      DIV_WAIT: begin
        if (cnt_q == '0) begin
          hilo_write = 1'b1;
          state_d    = FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef MCU_ILLEGAL_TRAP_EN
      TRAP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        state_d  = FETCH;
      end
`endif

      default: state_d = RESET;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (DIV_CYCLES=4).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic [4:0] rt;
  logic       mem_ready;
  logic [1:0] pc_src, reg_dst, hilo_rd;
  logic       mem_to_reg, origALU, equal, mem_read, write_enable_mem;
  logic       write_enable_reg, ir_write, pc_write, div_start, hilo_write, busy;
  logic [2:0] opALU;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  typedef struct packed {
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic       m2r;
    logic [1:0] hilo_rd;
    logic [2:0] opalu;
    logic       orig;
    logic       equal;
    logic       mrd;
    logic       wem;
    logic       wer;
    logic       irw;
    logic       pcw;
    logic       dstart;
    logic       hw;
    logic       busy;
  } outs_t;

  outs_t e;

  multicycle_control_unit #(
    .OPALU_W      (3),
    .DIV_CYCLES   (4),
    .RESET_PC_SRC (2'b11)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .opcode           (opcode),
    .funct            (funct),
    .rt               (rt),
    .mem_ready        (mem_ready),
    .pc_src           (pc_src),
    .reg_dst          (reg_dst),
    .mem_to_reg       (mem_to_reg),
    .hilo_rd          (hilo_rd),
    .opALU            (opALU),
    .origALU          (origALU),
    .equal            (equal),
    .mem_read         (mem_read),
    .write_enable_mem (write_enable_mem),
    .write_enable_reg (write_enable_reg),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .div_start        (div_start),
    .hilo_write       (hilo_write),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  function automatic outs_t base();
    outs_t r;
    r        = '0;
    r.pc_src = 2'b11;
    r.equal  = 1'b1;
    r.busy   = 1'b1;
    return r;
  endfunction

  function automatic outs_t fetch(input logic mr);
    outs_t r;
    r      = base();
    r.busy = 1'b0;
    r.mrd  = 1'b1;
    r.irw  = mr;
    r.pcw  = mr;
    return r;
  endfunction

  // opALU/origALU are only compared where the instruction fixes them
  task automatic chk(input string tag, input outs_t exp, input bit alu);
    outs_t       obs, m;
    logic [19:0] o, x;
    obs.pc_src  = pc_src;
    obs.reg_dst = reg_dst;
    obs.m2r     = mem_to_reg;
    obs.hilo_rd = hilo_rd;
    obs.opalu   = opALU;
    obs.orig    = origALU;
    obs.equal   = equal;
    obs.mrd     = mem_read;
    obs.wem     = write_enable_mem;
    obs.wer     = write_enable_reg;
    obs.irw     = ir_write;
    obs.pcw     = pc_write;
    obs.dstart  = div_start;
    obs.hw      = hilo_write;
    obs.busy    = busy;
    m = '1;
    if (!alu) begin
      m.opalu = '0;
      m.orig  = 1'b0;
    end
    o = obs & m;
    x = exp & m;
    n_cmp++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, o, x);
    end
  endtask

  task automatic cyc(input logic mr);
    @(posedge clk);
    #1;
    mem_ready = mr;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b001000;
    funct     = 6'b000000;
    rt        = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", base(), 1);
    rst_n = 1'b1;
    #1;
    chk("reset_release", base(), 1);

    // ADDI
    cyc(1); chk("addi_fetch", fetch(1), 0);
    cyc(1); chk("addi_decode", base(), 0);
    cyc(1); e = base(); e.orig = 1'b1; chk("addi_exec", e, 1);
    cyc(1); e.wer = 1'b1; chk("addi_wb", e, 1);
    opcode = 6'b000101;
    #1; chk("addi_wb_opcode_change", e, 1);

    // LW with two stall cycles in FETCH and in MEM
    opcode = 6'b100011;
    cyc(0); chk("lw_fetch_stall1", fetch(0), 0);
    cyc(0); chk("lw_fetch_stall2", fetch(0), 0);
    cyc(1); chk("lw_fetch_done", fetch(1), 0);
    cyc(1); chk("lw_decode", base(), 0);
    cyc(1); e = base(); e.orig = 1'b1; chk("lw_exec", e, 1);
    cyc(0); e.mrd = 1'b1; chk("lw_mem_stall1", e, 1);
    cyc(0); chk("lw_mem_stall2", e, 1);
    cyc(1); chk("lw_mem_done", e, 1);
    cyc(1); e = base(); e.orig = 1'b1; e.wer = 1'b1; e.m2r = 1'b1; chk("lw_wb", e, 1);

    // SW with one stall in MEM
    opcode = 6'b101011;
    cyc(1); chk("sw_fetch", fetch(1), 0);
    cyc(1); chk("sw_decode", base(), 0);
    cyc(1); e = base(); e.orig = 1'b1; chk("sw_exec", e, 1);
    cyc(0); e.wem = 1'b1; chk("sw_mem_stall", e, 1);
    cyc(1); chk("sw_mem_done", e, 1);

    // DIV
    opcode = 6'b000000; funct = 6'b011010;
    cyc(1); chk("div_fetch", fetch(1), 0);
    cyc(1); chk("div_decode", base(), 0);
    cyc(1); e = base(); e.dstart = 1'b1; chk("div_exec", e, 0);
    cyc(1); chk("div_wait1", base(), 0);
    cyc(1); chk("div_wait2", base(), 0);
    cyc(1); chk("div_wait3", base(), 0);
    cyc(1); e = base(); e.hw = 1'b1; chk("div_wait4_hilo", e, 0);

    // MFLO
    funct = 6'b010010;
    cyc(1); chk("mflo_fetch", fetch(1), 0);
    cyc(1); chk("mflo_decode", base(), 0);
    cyc(1); chk("mflo_exec", base(), 0);
    cyc(1); e = base(); e.wer = 1'b1; e.reg_dst = 2'd1; e.hilo_rd = 2'b10; chk("mflo_wb", e, 0);

    // BNE
    opcode = 6'b000101; funct = 6'b000000;
    cyc(1); chk("bne_fetch", fetch(1), 0);
    cyc(1); chk("bne_decode", base(), 0);
    cyc(1); e = base(); e.pcw = 1'b1; e.pc_src = 2'b00; e.equal = 1'b0; chk("bne_exec", e, 0);

    // BGEZAL
    opcode = 6'b000001; rt = 5'b10001;
    cyc(1); chk("bgezal_fetch", fetch(1), 0);
    cyc(1); chk("bgezal_decode", base(), 0);
    cyc(1); e = base(); e.pcw = 1'b1; e.pc_src = 2'b00; e.wer = 1'b1; e.reg_dst = 2'd2;
    chk("bgezal_exec", e, 0);

    // JAL
    opcode = 6'b000011; rt = 5'b00000;
    cyc(1); chk("jal_fetch", fetch(1), 0);
    cyc(1); chk("jal_decode", base(), 0);
    cyc(1); e = base(); e.pcw = 1'b1; e.pc_src = 2'b01; e.wer = 1'b1; e.reg_dst = 2'd2;
    chk("jal_exec", e, 0);

    // Unknown opcode
    opcode = 6'b111111;
    cyc(1); chk("illegal_fetch", fetch(1), 0);
    cyc(1); chk("illegal_decode", base(), 0);
    cyc(1); chk("illegal_exec", base(), 0);
`ifdef MCU_ILLEGAL_TRAP_EN
    cyc(1); e = base(); e.pcw = 1'b1; e.pc_src = 2'b01; chk("illegal_trap", e, 0);
`endif
    cyc(1); chk("illegal_back_to_fetch", fetch(1), 0);

    // DIV aborted by reset in the second DIV_WAIT cycle
    opcode = 6'b000000; funct = 6'b011010;
    cyc(1); chk("div2_decode", base(), 0);
    cyc(1); e = base(); e.dstart = 1'b1; chk("div2_exec", e, 0);
    cyc(1); chk("div2_wait1", base(), 0);
    cyc(1); chk("div2_wait2", base(), 0);
    #2;
    rst_n = 1'b0;
    #1; chk("div2_async_reset", base(), 1);
    @(posedge clk); #1; chk("div2_reset_hold", base(), 1);
    @(posedge clk); #1; chk("div2_reset_hold2", base(), 1);
    rst_n = 1'b1;
    #1; chk("div2_reset_release", base(), 1);
    cyc(1); chk("div2_restart_fetch", fetch(1), 0);
    cyc(1); chk("div2_restart_decode", base(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule
